fifo_ram_ctrl: RTL and testbench

Controller that turns the single-port 256x8 `ram` (synchronous write, combinational read, one shared address) into a FIFO. It owns the write/read pointers and occupancy count, and arbitrates between a push requester and a pop requester. Because the RAM has one address port, it grants at most one access per cycle, round-robin on conflict. It sits between the producer/consumer logic and the `ram` instance in the FIFO datapath.

---
 rtl/fifo_ram_ctrl.sv | 126 ++++++++++++
 tb/tb_fifo_ram_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ram_ctrl
//  Purpose  : FIFO controller for a single-port RAM (synchronous write,
//             combinational read, shared address). Owns the read/write
//             pointers and occupancy count and grants at most one of push
//             or pop per cycle, round-robin when both are eligible.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_ram_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  push_req_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic                  push_ack_o,
    input  logic                  pop_req_i,
    output logic                  pop_ack_o,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  pop_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_wr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

    // Occupancy value meaning "full": exactly 2**ADDR_WIDTH entries.
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    // Round-robin memory of which side won the most recent grant.
    localparam logic GRANT_POP  = 1'b0;
    localparam logic GRANT_PUSH = 1'b1;

    logic [ADDR_WIDTH-1:0] wptr_q,       wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q,       rptr_d;
    logic [ADDR_WIDTH:0]   count_q,      count_d;
    logic                  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] pop_data_q,   pop_data_d;
    logic                  pop_valid_q,  pop_valid_d;

    logic push_elig;
    logic pop_elig;
    logic grant_push;
    logic grant_pop;

    assign full_o      = (count_q == FULL_COUNT);
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign pop_data_o  = pop_data_q;
    assign pop_valid_o = pop_valid_q;

    // Eligibility and arbitration; the loser of a conflict is the side that won last time.
    always_comb begin
        push_elig  = push_req_i && !full_o  && !clr_i;
        pop_elig   = pop_req_i  && !empty_o && !clr_i;
        grant_push = push_elig && (!pop_elig || (last_grant_q == GRANT_POP));
        grant_pop  = pop_elig && !grant_push;
    end

    // RAM port drive; reset gates acks and the write strobe so an in-flight write is dropped.
    always_comb begin
        push_ack_o  = grant_push && rst_n;
        pop_ack_o   = grant_pop  && rst_n;
        ram_wr_o    = grant_push && rst_n;
        ram_wdata_o = push_data_i;
        if (!rst_n) begin
            ram_addr_o = '0;
        end else if (grant_push) begin
            ram_addr_o = wptr_q;
        end else begin
            ram_addr_o = rptr_q;
        end
    end

    // Next-state computation for pointers, count, arbitration history and read port.
    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        pop_data_d   = pop_data_q;
        pop_valid_d  = 1'b0;
        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else if (grant_push) begin
            wptr_d       = wptr_q + 1'b1;
            count_d      = count_q + 1'b1;
            last_grant_d = GRANT_PUSH;
        end else if (grant_pop) begin
            rptr_d       = rptr_q + 1'b1;
            count_d      = count_q - 1'b1;
            last_grant_d = GRANT_POP;
            pop_data_d   = ram_rdata_i;
            pop_valid_d  = 1'b1;
        end
    end

    // State registers; asynchronous reset leaves arbitration favouring push first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            last_grant_q <= GRANT_POP;
            pop_data_q   <= '0;
            pop_valid_q  <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            pop_data_q   <= pop_data_d;
            pop_valid_q  <= pop_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_ram_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_fifo_ram_ctrl
//  Purpose  : Self-checking bench for fifo_ram_ctrl with a behavioural
//             256x8 single-port RAM attached.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       push_req;
    logic [7:0] push_data;
    logic       push_ack;
    logic       pop_req;
    logic       pop_ack;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic       full;
    logic       empty;
    logic [8:0] count;
    logic [7:0] ram_addr;
    logic       ram_wr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    logic [7:0] mem [256];

    int total = 0;
    int bad   = 0;
    logic [7:0] q_model [$];

    typedef struct {
        logic       push;
        logic       pop;
        logic       clr;
        logic [7:0] din;
        logic       e_pack;
        logic       e_oack;
        logic       e_wr;
        logic [7:0] e_addr;
        logic [8:0] e_cnt;
        logic       e_pv;
        logic [7:0] e_pd;
    } vec_t;

    vec_t vecs [17];

    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, combinational read.
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    fifo_ram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clr),
        .push_req_i  (push_req),
        .push_data_i (push_data),
        .push_ack_o  (push_ack),
        .pop_req_i   (pop_req),
        .pop_ack_o   (pop_ack),
        .pop_data_o  (pop_data),
        .pop_valid_o (pop_valid),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count),
        .ram_addr_o  (ram_addr),
        .ram_wr_o    (ram_wr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; push_req = 1'b0; pop_req = 1'b0; clr = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        q_model.delete();
    endtask

    task automatic push1(input logic [7:0] d);
        push_req = 1'b1; push_data = d;
        #1 chk("push1_ack", {31'd0, push_ack}, 32'd1);
        cyc();
        push_req = 1'b0;
        q_model.push_back(d);
    endtask

    task automatic pop1();
        logic [7:0] e;
        pop_req = 1'b1;
        #1 chk("pop1_ack", {31'd0, pop_ack}, 32'd1);
        cyc();
        pop_req = 1'b0;
        e = q_model.pop_front();
        chk("pop1_valid", {31'd0, pop_valid}, 32'd1);
        chk("pop1_data", {24'd0, pop_data}, {24'd0, e});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       exp_push;
        logic [8:0] exp_cnt;
        logic [7:0] e;

        //           push pop clr din    pack oack wr  addr   cnt   pv   pd
        vecs[0]  = '{1'b1,1'b0,1'b0,8'h55,1'b1,1'b0,1'b1,8'd0,9'd1,1'b0,8'h00};
        vecs[1]  = '{1'b1,1'b0,1'b0,8'h56,1'b1,1'b0,1'b1,8'd1,9'd2,1'b0,8'h00};
        vecs[2]  = '{1'b1,1'b0,1'b0,8'h88,1'b1,1'b0,1'b1,8'd2,9'd3,1'b0,8'h00};
        vecs[3]  = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b1,1'b0,8'd0,9'd2,1'b1,8'h55};
        vecs[4]  = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b1,1'b0,8'd1,9'd1,1'b1,8'h56};
        vecs[5]  = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b1,1'b0,8'd2,9'd0,1'b1,8'h88};
        vecs[6]  = '{1'b1,1'b1,1'b0,8'h11,1'b1,1'b0,1'b1,8'd3,9'd1,1'b0,8'h88};
        vecs[7]  = '{1'b1,1'b1,1'b0,8'h22,1'b0,1'b1,1'b0,8'd3,9'd0,1'b1,8'h11};
        vecs[8]  = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,8'd4,9'd0,1'b0,8'h11};
        vecs[9]  = '{1'b1,1'b0,1'b0,8'h33,1'b1,1'b0,1'b1,8'd4,9'd1,1'b0,8'h11};
        vecs[10] = '{1'b1,1'b0,1'b0,8'h44,1'b1,1'b0,1'b1,8'd5,9'd2,1'b0,8'h11};
        vecs[11] = '{1'b1,1'b1,1'b0,8'h99,1'b0,1'b1,1'b0,8'd4,9'd1,1'b1,8'h33};
        vecs[12] = '{1'b1,1'b1,1'b0,8'h99,1'b1,1'b0,1'b1,8'd6,9'd2,1'b0,8'h33};
        vecs[13] = '{1'b1,1'b1,1'b0,8'h99,1'b0,1'b1,1'b0,8'd5,9'd1,1'b1,8'h44};
        vecs[14] = '{1'b1,1'b1,1'b1,8'h77,1'b0,1'b0,1'b0,8'd6,9'd0,1'b0,8'h44};
        vecs[15] = '{1'b1,1'b0,1'b0,8'hA5,1'b1,1'b0,1'b1,8'd0,9'd1,1'b0,8'h44};
        vecs[16] = '{1'b0,1'b1,1'b0,8'h00,1'b0,1'b1,1'b0,8'd0,9'd0,1'b1,8'hA5};

        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;

        // Reset state, with a push request asserted while reset is low.
        rst_n = 1'b0; clr = 1'b0; pop_req = 1'b0;
        push_req = 1'b1; push_data = 8'hC3;
        #2;
        chk("rst_push_ack", {31'd0, push_ack}, 32'd0);
        chk("rst_ram_wr",   {31'd0, ram_wr},   32'd0);
        chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
        cyc(); cyc();
        push_req = 1'b0;
        rst_n = 1'b1;
        chk("rst_count", {23'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full",  {31'd0, full},  32'd0);
        chk("rst_pv",    {31'd0, pop_valid}, 32'd0);
        chk("rst_pd",    {24'd0, pop_data},  32'd0);

        // Table-driven vectors: basic push/pop, arbitration, no-bypass, flush.
        for (int i = 0; i < 17; i++) begin
            push_req = vecs[i].push; pop_req = vecs[i].pop;
            clr = vecs[i].clr; push_data = vecs[i].din;
            #1;
            chk($sformatf("v%0d_push_ack", i), {31'd0, push_ack}, {31'd0, vecs[i].e_pack});
            chk($sformatf("v%0d_pop_ack", i),  {31'd0, pop_ack},  {31'd0, vecs[i].e_oack});
            chk($sformatf("v%0d_ram_wr", i),   {31'd0, ram_wr},   {31'd0, vecs[i].e_wr});
            chk($sformatf("v%0d_ram_addr", i), {24'd0, ram_addr}, {24'd0, vecs[i].e_addr});
            if (vecs[i].e_wr)
                chk($sformatf("v%0d_ram_wdata", i), {24'd0, ram_wdata}, {24'd0, vecs[i].din});
            cyc();
            chk($sformatf("v%0d_count", i), {23'd0, count}, {23'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d_empty", i), {31'd0, empty}, {31'd0, (vecs[i].e_cnt == 9'd0)});
            chk($sformatf("v%0d_pop_valid", i), {31'd0, pop_valid}, {31'd0, vecs[i].e_pv});
            chk($sformatf("v%0d_pop_data", i),  {24'd0, pop_data},  {24'd0, vecs[i].e_pd});
        end
        push_req = 1'b0; pop_req = 1'b0; clr = 1'b0;

        // Fill to full, reject the extra push, then drain in order.
        reset_dut();
        for (int i = 0; i < 256; i++) begin
            push_req = 1'b1; push_data = 8'(i);
            #1 chk("fill_ack", {31'd0, push_ack}, 32'd1);
            cyc();
        end
        chk("fill_full",  {31'd0, full},  32'd1);
        chk("fill_count", {23'd0, count}, 32'd256);
        push_data = 8'hEE;
        #1;
        chk("over_push_ack", {31'd0, push_ack}, 32'd0);
        chk("over_ram_wr",   {31'd0, ram_wr},   32'd0);
        cyc();
        chk("over_count", {23'd0, count},  32'd256);
        chk("over_mem0",  {24'd0, mem[0]}, 32'd0);
        pop_req = 1'b1;
        #1;
        chk("full_both_pop_ack",  {31'd0, pop_ack},  32'd1);
        chk("full_both_push_ack", {31'd0, push_ack}, 32'd0);
        cyc();
        push_req = 1'b0;
        chk("full_both_pv",   {31'd0, pop_valid}, 32'd1);
        chk("full_both_pd",   {24'd0, pop_data},  32'd0);
        chk("full_both_full", {31'd0, full},      32'd0);
        for (int i = 1; i < 256; i++) begin
            #1 chk("drain_ack", {31'd0, pop_ack}, 32'd1);
            cyc();
            chk("drain_data", {24'd0, pop_data}, i);
        end
        pop_req = 1'b0;
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // Continuous conflict from count=4 with last grant on pop: push first, then alternate.
        reset_dut();
        for (int i = 0; i < 5; i++) push1(8'(8'h10 + i));
        pop1();
        exp_cnt = 9'd4;
        push_req = 1'b1; pop_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push_data = 8'(8'h20 + k);
            exp_push = (k % 2 == 0);
            #1;
            chk("alt_push_ack", {31'd0, push_ack}, {31'd0, exp_push});
            chk("alt_pop_ack",  {31'd0, pop_ack},  {31'd0, !exp_push});
            chk("alt_wr_on_pop", {31'd0, ram_wr & pop_ack}, 32'd0);
            if (exp_push) begin
                q_model.push_back(push_data);
                exp_cnt = exp_cnt + 9'd1;
            end else begin
                exp_cnt = exp_cnt - 9'd1;
            end
            cyc();
            chk("alt_count", {23'd0, count}, {23'd0, exp_cnt});
            if (!exp_push) begin
                e = q_model.pop_front();
                chk("alt_pop_data", {24'd0, pop_data}, {24'd0, e});
            end
        end
        push_req = 1'b0; pop_req = 1'b0;

        // Pointer wrap with occupancy near two.
        reset_dut();
        push1(8'd0); push1(8'd1);
        for (int i = 2; i < 302; i++) begin
            push1(8'(i));
            pop1();
        end
        pop1(); pop1();
        chk("wrap_empty", {31'd0, empty}, 32'd1);

        // Asynchronous reset during a granted push.
        for (int i = 0; i < 7; i++) push1(8'(8'h70 + i));
        chk("mid_count7", {23'd0, count}, 32'd7);
        push_req = 1'b1; push_data = 8'h5A;
        #1 chk("mid_push_ack_pre", {31'd0, push_ack}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_ram_wr",   {31'd0, ram_wr},    32'd0);
        chk("mid_push_ack", {31'd0, push_ack},  32'd0);
        chk("mid_ram_addr", {24'd0, ram_addr},  32'd0);
        chk("mid_count",    {23'd0, count},     32'd0);
        chk("mid_empty",    {31'd0, empty},     32'd1);
        chk("mid_pv",       {31'd0, pop_valid}, 32'd0);
        chk("mid_pd",       {24'd0, pop_data},  32'd0);
        push_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        q_model.delete();
        push1(8'h3C);
        pop1();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
